lcd1602_seq: RTL and testbench

LCD1602_SEQ -- requirements
Module: lcd1602_seq

---
 rtl/lcd1602_pkg.sv | 21 ++
 rtl/lcd1602_delay_cnt.sv | 19 +
 rtl/lcd1602_seq.sv | 101 ++++++++++
 tb/tb_lcd1602_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// lcd1602_pkg: shared states, init command table and clear/home detection for lcd1602_seq.
package lcd1602_pkg;
  typedef enum logic [2:0] {PWRUP, INIT_LOAD, IDLE, SETUP, EN_HI, HOLD, WAIT} state_t;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
`ifdef LCD1602_SEQ_INIT_EN
  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h01, 8'h06, 8'h0C, 8'h38};
`endif
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return m < 2 ? 1 : $clog2(m + 1);
  endfunction
  // home ignores bit 0, so 0x02 and 0x03 both take the long wait
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d == CMD_CLEAR || d[7:1] == CMD_HOME[7:1]);
  endfunction
endpackage

// File: rtl/lcd1602_delay_cnt.sv
// lcd1602_delay_cnt: reloadable down-counter; done marks the last cycle of a loaded interval.
module lcd1602_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         done,
  output logic         idle
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start) cnt <= load;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == W'(1);
  assign idle = cnt == '0;
endmodule

// File: rtl/lcd1602_seq.sv
// lcd1602_seq: HD44780/1602 write sequencer with enable pulse and settle timing.
// Define LCD1602_SEQ_INIT_EN to add the power-up wait and built-in init command sequence.
module lcd1602_seq import lcd1602_pkg::*; #(
  parameter int EN_HIGH_CYC  = 16,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 80000,
  parameter int PWRUP_CYC    = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ack,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);
  localparam int W = cnt_width(EN_HIGH_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC, PWRUP_CYC);
  state_t state;
  logic dly_start, dly_done, dly_idle;
  logic [W-1:0] dly_load;
`ifdef LCD1602_SEQ_INIT_EN
  logic [1:0] idx;
`endif
  // PWRUP arms itself on its first cycle, so it spans PWRUP_CYC cycles in total
  always_comb begin
    dly_start = (state == PWRUP && dly_idle) || state == SETUP || state == HOLD;
    dly_load = state == PWRUP ? W'(PWRUP_CYC - 1) :
               state == SETUP ? W'(EN_HIGH_CYC) :
               is_slow_cmd(lcd_rs, lcd_data) ? W'(CLR_WAIT_CYC) : W'(CMD_WAIT_CYC);
  end
  lcd1602_delay_cnt #(.W(W)) u_dly (
    .clk(clk), .rst_n(rst_n), .start(dly_start), .load(dly_load), .done(dly_done), .idle(dly_idle)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LCD1602_SEQ_INIT_EN
      state <= PWRUP;
      idx <= '0;
`else
      state <= IDLE;
`endif
      ack <= 1'b0;
      init_done <= 1'b0;
      lcd_en <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_data <= '0;
    end else begin
      ack <= 1'b0;
`ifndef LCD1602_SEQ_INIT_EN
      init_done <= 1'b1;
`endif
      case (state)
`ifdef LCD1602_SEQ_INIT_EN
        PWRUP: if (dly_done) state <= INIT_LOAD;
        INIT_LOAD: begin
          lcd_rs <= 1'b0;
          lcd_data <= INIT_ROM[idx];
          state <= SETUP;
        end
`endif
        IDLE: if (req && init_done) begin
          ack <= 1'b1;
          lcd_rs <= rs_in;
          lcd_data <= data_in;
          state <= SETUP;
        end
        SETUP: begin
          lcd_en <= 1'b1;
          state <= EN_HI;
        end
        EN_HI: if (dly_done) begin
          lcd_en <= 1'b0;
          state <= HOLD;
        end
        HOLD: state <= WAIT;
        WAIT: if (dly_done) begin
`ifdef LCD1602_SEQ_INIT_EN
          if (init_done) state <= IDLE;
          else if (idx == 2'(INIT_LEN - 1)) begin
            init_done <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + 2'd1;
            state <= INIT_LOAD;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign lcd_rw = 1'b0;
endmodule

// File: tb/tb_lcd1602_seq.sv
// tb_lcd1602_seq: randomized writes against a bus-level timing model with a queue scoreboard.
module tb_lcd1602_seq;
  localparam int EN = 2, CMD = 4, CLR = 8, PWR = 10, TMO = 500;
  logic clk, rst_n, req, rs_in, ack, busy, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] data_in, lcd_data;
  typedef struct {
    logic rs;
    logic [7:0] d;
    int w;
    logic chain;
    logic is_init;
    logic last_init;
  } exp_t;
  exp_t exq[$];
  int checks = 0, errors = 0, ack_cnt = 0, req_cnt = 0;
  lcd1602_seq #(.EN_HIGH_CYC(EN), .CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR), .PWRUP_CYC(PWR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rs_in(rs_in), .data_in(data_in), .ack(ack),
    .busy(busy), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLR : CMD;
  endfunction
  task automatic push_init();
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    exq.delete();
`ifdef LCD1602_SEQ_INIT_EN
    for (int i = 0; i < 4; i++)
      exq.push_back('{rs: 1'b0, d: cmds[i], w: wait_of(1'b0, cmds[i]), chain: i < 3, is_init: 1'b1, last_init: i == 3});
`endif
  endtask
  task automatic do_req(input logic rs, input logic [7:0] d);
    int t;
    t = 0;
    rs_in = rs;
    data_in = d;
    req = 1'b1;
    req_cnt++;
    do begin
      @(negedge clk);
      t++;
    end while (!ack && t < TMO);
    chk("ack_seen", ack, 1);
    if (ack) begin
      exq.push_back('{rs: rs, d: d, w: wait_of(rs, d), chain: 1'b0, is_init: 1'b0, last_init: 1'b0});
      chk("ack_after_init", init_done, 1);
      chk("accept_rs", lcd_rs, rs);
      chk("accept_data", lcd_data, d);
      chk("accept_busy", busy, 1);
      chk("accept_en_low", lcd_en, 0);
    end
    req = 1'b0;
    rs_in = 1'($urandom);
    data_in = 8'($urandom);
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
    chk("en_latency", lcd_en, 1);
  endtask
  task automatic reset_and_start(input logic rs, input logic [7:0] d);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_init_done", init_done, 0);
`ifdef LCD1602_SEQ_INIT_EN
    chk("rst_busy", busy, 1);
`else
    chk("rst_busy", busy, 0);
`endif
    push_init();
    rst_n = 1'b1;
    fork
      begin
`ifdef LCD1602_SEQ_INIT_EN
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!lcd_en && n < 100);
        chk("first_en_latency", n, PWR + 2);
`else
        @(negedge clk);
        chk("init_done_no_init", init_done, 1);
`endif
      end
      do_req(rs, d);
    join
  endtask
  initial begin : monitor
    exp_t cur;
    int ph, g, wid;
    ph = 0;
    g = 0;
    wid = 0;
    cur = '{rs: 1'b0, d: 8'h00, w: 0, chain: 1'b0, is_init: 1'b0, last_init: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = 0;
        continue;
      end
      if (ph == 2) begin
        g++;
        if (lcd_en || !busy) begin
          chk("gap", g, cur.chain ? cur.w + 3 : cur.w + 1);
          if (cur.last_init) chk("init_done_rise", init_done, 1);
          ph = 0;
        end else if (g <= cur.w) begin
          chk("wait_rs_stable", lcd_rs, cur.rs);
          chk("wait_data_stable", lcd_data, cur.d);
        end
      end else if (ph == 1) begin
        chk("en_rs_stable", lcd_rs, cur.rs);
        chk("en_data_stable", lcd_data, cur.d);
        if (lcd_en) wid++;
        else begin
          chk("en_width", wid, EN);
          g = 0;
          ph = 2;
        end
      end
      if (ph == 0 && lcd_en) begin
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: rs %0b data %0h with nothing expected", lcd_rs, lcd_data);
        end else begin
          cur = exq.pop_front();
          chk("write_rs", lcd_rs, cur.rs);
          chk("write_data", lcd_data, cur.d);
          if (cur.is_init) chk("init_done_low", init_done, 0);
        end
        wid = 1;
        ph = 1;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && ack === 1'b1) ack_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    logic rs;
    logic [7:0] d;
    rst_n = 1'b1;
    req = 1'b0;
    rs_in = 1'b0;
    data_in = 8'h00;
    #1 rst_n = 1'b0;
    reset_and_start(1'b1, 8'h41);
    do_req(1'b0, 8'h01);
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        rs = 1'b0;
        d = 8'($urandom_range(1, 3));
      end else begin
        rs = 1'($urandom);
        d = 8'($urandom);
      end
      do_req(rs, d);
    end
    do_req(1'b1, 8'h5A);
    #2 rst_n = 1'b0;
    #1 chk("async_en_drop", lcd_en, 0);
    chk("async_data_clear", lcd_data, 0);
    chk("async_rs_clear", lcd_rs, 0);
    chk("async_init_done_clear", init_done, 0);
    reset_and_start(1'b0, 8'h02);
    do_req(1'b1, 8'($urandom));
    t = 0;
    while ((busy || exq.size() != 0) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drained_busy", busy, 0);
    chk("queue_empty", exq.size(), 0);
    chk("ack_count", ack_cnt, req_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
